ps2_rx_fifo: RTL and testbench

Parametrised PS/2 keyboard receiver with scan-code decoding and event buffering. It oversamples `ps2_clk`/`ps2_data` in the system clock domain, checks each 11-bit frame, and folds `E0`/`F0` prefixes into a single key event carrying break and extended flags. Events are queued in a `DEPTH`-entry FIFO with a valid/ready pop port. It is the front end between the keyboard pins and the display/counter logic in `top`, and replaces the single-register receiver and the separate press detector.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_evt_fifo.sv | 71 +++++++
 rtl/ps2_rx_fifo.sv | 219 +++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared types and constants for the PS/2 receive path.
//   ps2_dec_state_t : scan-code prefix decoder states
//   ps2_evt_t       : one decoded key event {brk, ext, code}
//   PS2_PREFIX_EXT  : extended-key prefix byte
//   PS2_PREFIX_BRK  : key-release prefix byte
package ps2_pkg;

    typedef enum logic [1:0] {
        DEC_IDLE    = 2'd0,
        DEC_EXT     = 2'd1,
        DEC_BRK     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } ps2_dec_state_t;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic ps2_odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo -- synchronous FIFO of decoded key events.
//   clk, resetn : clock, asynchronous active-low reset
//   push        : write push_evt (taken when not full, or when a pop happens the same cycle)
//   push_evt    : event to write
//   pop         : advance the head (ignored when empty)
//   head_evt    : current head event, all-zero when empty
//   full, empty : occupancy flags
//   level       : number of stored events
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  ps2_evt_t                 push_evt,
    input  logic                     pop,
    output ps2_evt_t                 head_evt,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    ps2_evt_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level_q;
    logic            wr_en;
    logic            rd_en;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

    assign rd_en = pop && !empty;
    // A simultaneous pop frees the slot being written, so a full FIFO still accepts.
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_evt;
        end
    end

    assign head_evt = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo -- PS/2 keyboard receiver with prefix folding and event FIFO.
//   clk, resetn        : system clock, asynchronous active-low reset
//   ps2_clk, ps2_data  : raw keyboard pins (asynchronous)
//   evt_valid/evt_ready: pop handshake on the event FIFO head
//   evt_code/break/ext : head event (zero when empty)
//   level              : FIFO occupancy
//   overflow           : sticky event-dropped flag, cleared by clr_overflow
//   frame_err          : one-cycle pulse per rejected frame
//   err_count          : saturating rejected-frame count
// Build option: define PS2_RX_TIMEOUT_EN to abandon a frame after
// TIMEOUT_CYCLES clk cycles without a PS/2 clock edge mid-frame.
//
// Decoder states:
//   state       | meaning
//   DEC_IDLE    | no prefix pending
//   DEC_EXT     | E0 seen
//   DEC_BRK     | F0 seen
//   DEC_EXT_BRK | E0 then F0 seen
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [7:0]               evt_code,
    output logic                     evt_break,
    output logic                     evt_ext,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic                     frame_err,
    output logic [7:0]               err_count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("ps2_rx_fifo: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 2");
    end

    // Synchronisers idle high so releasing reset never looks like a falling edge.
    logic [2:0] sync_clk;
    logic [1:0] sync_data;
    logic       strobe;
    logic       data_s;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_clk  <= 3'b111;
            sync_data <= 2'b11;
        end else begin
            sync_clk  <= {sync_clk[1:0], ps2_clk};
            sync_data <= {sync_data[0], ps2_data};
        end
    end

    assign strobe = sync_clk[2] & ~sync_clk[1];
    assign data_s = sync_data[1];

    // frame_buf[0] = start, [8:1] = data LSB first, [9] = parity; stop is the live sample.
    logic [3:0] bit_cnt;
    logic [9:0] frame_buf;
    logic       byte_done;
    logic       frame_good;
    logic       frame_bad;
    logic       wd_expire;
    logic [7:0] rx_byte;

    assign rx_byte    = frame_buf[8:1];
    assign byte_done  = strobe && (bit_cnt == 4'd10);
    assign frame_good = byte_done && !frame_buf[0] && data_s
                        && ps2_odd_parity_ok(rx_byte, frame_buf[9]);
    assign frame_bad  = (byte_done && !frame_good) || wd_expire;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt   <= '0;
            frame_buf <= '0;
        end else if (wd_expire) begin
            bit_cnt <= '0;
        end else if (strobe) begin
            if (bit_cnt == 4'd10) begin
                bit_cnt <= '0;
            end else begin
                frame_buf[bit_cnt] <= data_s;
                bit_cnt            <= bit_cnt + 1'b1;
            end
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    // Down-counter reloaded on every edge and while idle; expiry lands frame_err
    // TIMEOUT_CYCLES cycles after the last strobe.
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt <= '0;
        end else if (strobe || (bit_cnt == '0)) begin
            wd_cnt <= WD_W'(TIMEOUT_CYCLES - 2);
        end else if (wd_cnt != '0) begin
            wd_cnt <= wd_cnt - 1'b1;
        end
    end

    assign wd_expire = (bit_cnt != '0) && !strobe && (wd_cnt == '0);
`else
    assign wd_expire = 1'b0;
`endif

    ps2_dec_state_t state;
    ps2_dec_state_t next_state;
    logic           emit;
    ps2_evt_t       emit_evt;
    logic           is_ext;
    logic           is_brk;

    assign is_ext = (state == DEC_EXT) || (state == DEC_EXT_BRK);
    assign is_brk = (state == DEC_BRK) || (state == DEC_EXT_BRK);

    always_comb begin
        next_state    = state;
        emit          = 1'b0;
        emit_evt.brk  = is_brk;
        emit_evt.ext  = is_ext;
        emit_evt.code = rx_byte;
        if (frame_bad) begin
            next_state = DEC_IDLE;
        end else if (frame_good) begin
            unique case (state)
                DEC_IDLE: begin
                    if (rx_byte == PS2_PREFIX_EXT) begin
                        next_state = DEC_EXT;
                    end else if (rx_byte == PS2_PREFIX_BRK) begin
                        next_state = DEC_BRK;
                    end else begin
                        emit = 1'b1;
                    end
                end
                DEC_EXT: begin
                    if (rx_byte == PS2_PREFIX_BRK) begin
                        next_state = DEC_EXT_BRK;
                    end else if (rx_byte != PS2_PREFIX_EXT) begin
                        emit = 1'b1;
                    end
                end
                default: begin
                    if (rx_byte != PS2_PREFIX_BRK) begin
                        emit = 1'b1;
                    end
                end
            endcase
            if (emit) begin
                next_state = DEC_IDLE;
            end
        end
    end

    logic      evt_push_q;
    ps2_evt_t  evt_q;
    ps2_evt_t  head_evt;
    logic      fifo_full;
    logic      fifo_empty;
    logic      pop;

    assign pop = evt_valid && evt_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= DEC_IDLE;
            evt_push_q <= 1'b0;
            evt_q      <= '0;
            frame_err  <= 1'b0;
            err_count  <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= next_state;
            evt_push_q <= emit;
            if (emit) begin
                evt_q <= emit_evt;
            end
            frame_err <= frame_bad;
            if (frame_bad && (err_count != 8'hFF)) begin
                err_count <= err_count + 1'b1;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (evt_push_q && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_evt_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (evt_push_q),
        .push_evt (evt_q),
        .pop      (pop),
        .head_evt (head_evt),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    assign evt_valid = !fifo_empty;
    assign evt_code  = head_evt.code;
    assign evt_break = head_evt.brk;
    assign evt_ext   = head_evt.ext;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int TMO   = 200;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       evt_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;
    logic [3:0] level;
    logic       overflow;
    logic       frame_err;
    logic [7:0] err_count;

    ps2_rx_fifo #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_break    (evt_break),
        .evt_ext      (evt_ext),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .frame_err    (frame_err),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int err_pulses = 0;

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_pulses++;
    end

    typedef struct {
        bit         send;
        logic [7:0] code;
        bit         bad_par;
        bit         bad_stop;
        int         npop;
        int         exp_level;
        logic [7:0] exp_code;
        bit         exp_brk;
        bit         exp_ext;
        int         exp_errc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input bit s, input logic [7:0] c, input bit bp, input bit bs,
                                 input int np, input int lv, input logic [7:0] ec,
                                 input bit eb, input bit ee, input int erc);
        vec_t v;
        v.send = s; v.code = c; v.bad_par = bp; v.bad_stop = bs; v.npop = np;
        v.exp_level = lv; v.exp_code = ec; v.exp_brk = eb; v.exp_ext = ee; v.exp_errc = erc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_head(input string tag, input int lv, input logic [7:0] c,
                            input bit b, input bit e);
        chk({tag, "_level"}, 32'(level), 32'(lv));
        chk({tag, "_valid"}, 32'(evt_valid), (lv != 0) ? 32'd1 : 32'd0);
        chk({tag, "_code"},  32'(evt_code), 32'(c));
        chk({tag, "_break"}, 32'(evt_break), 32'(b));
        chk({tag, "_ext"},   32'(evt_ext), 32'(e));
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] c, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^c) ^ bad_par;
        return {~bad_stop, par, c, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] c, input bit bp = 0, input bit bs = 0);
        send_bits(mk_frame(c, bp, bs), 11);
        repeat (10) @(negedge clk);
    endtask

    task automatic pop1();
        @(negedge clk) evt_ready = 1'b1;
        @(negedge clk) evt_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_level"},     32'(level), 32'd0);
        chk({tag, "_valid"},     32'(evt_valid), 32'd0);
        chk({tag, "_code"},      32'(evt_code), 32'd0);
        chk({tag, "_break"},     32'(evt_break), 32'd0);
        chk({tag, "_ext"},       32'(evt_ext), 32'd0);
        chk({tag, "_overflow"},  32'(overflow), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        logic [10:0] f;
        int base;
        int n;
        int got;

        // send code  bp bs pop | level code brk ext errc
        vecs.push_back(mkv(1, 8'h1C, 0, 0, 0, 1, 8'h1C, 0, 0, 0));
        vecs.push_back(mkv(1, 8'hF0, 0, 0, 0, 1, 8'h1C, 0, 0, 0));
        vecs.push_back(mkv(1, 8'h1C, 0, 0, 0, 2, 8'h1C, 0, 0, 0));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 1, 1, 8'h1C, 1, 0, 0));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mkv(1, 8'hE0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mkv(1, 8'hF0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mkv(1, 8'h75, 0, 0, 0, 1, 8'h75, 1, 1, 0));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mkv(1, 8'h1C, 1, 0, 0, 0, 8'h00, 0, 0, 1));
        vecs.push_back(mkv(1, 8'hE0, 0, 1, 0, 0, 8'h00, 0, 0, 2));
        vecs.push_back(mkv(1, 8'h74, 0, 0, 0, 1, 8'h74, 0, 0, 2));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 2));
        vecs.push_back(mkv(1, 8'hE1, 0, 0, 0, 1, 8'hE1, 0, 0, 2));
        vecs.push_back(mkv(1, 8'hE0, 0, 0, 0, 1, 8'hE1, 0, 0, 2));
        vecs.push_back(mkv(1, 8'h12, 0, 0, 0, 2, 8'hE1, 0, 0, 2));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 1, 1, 8'h12, 0, 1, 2));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 2));

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].send) send_byte(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop);
            for (int p = 0; p < vecs[i].npop; p++) pop1();
            chk_head($sformatf("row%0d", i), vecs[i].exp_level, vecs[i].exp_code,
                     vecs[i].exp_brk, vecs[i].exp_ext);
            chk($sformatf("row%0d_err_count", i), 32'(err_count), 32'(vecs[i].exp_errc));
            chk($sformatf("row%0d_err_pulses", i), 32'(err_pulses), 32'(vecs[i].exp_errc));
            chk($sformatf("row%0d_overflow", i), 32'(overflow), 32'd0);
        end

        // Fill to DEPTH, then one more is dropped.
        for (int i = 0; i < DEPTH; i++) send_byte(8'h10 + 8'(i));
        chk("fill_level", 32'(level), 32'd8);
        chk("fill_overflow", 32'(overflow), 32'd0);
        send_byte(8'h18);
        chk_head("ovf", 8, 8'h10, 0, 0);
        chk("ovf_overflow", 32'(overflow), 32'd1);
        @(negedge clk) clr_overflow = 1'b1;
        @(negedge clk) clr_overflow = 1'b0;
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_level", 32'(level), 32'd8);

        // Push 18 again at full while popping on exactly the FIFO write edge.
        f = mk_frame(8'h18, 0, 0);
        send_bits(f, 10);
        @(negedge clk) ps2_data = f[10];
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        evt_ready = 1'b1;
        @(negedge clk) evt_ready = 1'b0;
        repeat (6) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        chk_head("pushpop", 8, 8'h11, 0, 0);
        chk("pushpop_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 7; i++) begin
            pop1();
            chk_head($sformatf("drain%0d", i), 7 - i, 8'h12 + 8'(i), 0, 0);
        end
        pop1();
        chk_head("drain_end", 0, 8'h00, 0, 0);

        // Reset during the 6th bit of a frame.
        send_byte(8'h33);
        chk("prerst_level", 32'(level), 32'd1);
        chk("prerst_err_count", 32'(err_count), 32'd2);
        f = mk_frame(8'h1C, 0, 0);
        send_bits(f, 5);
        @(negedge clk) ps2_data = f[5];
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        check_all_zero("rst_midframe");
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(8'h1C);
        chk_head("after_rst1", 1, 8'h1C, 0, 0);
        pop1();

        // Reset while an E0 prefix is pending.
        send_byte(8'h1C);
        send_byte(8'hE0);
        chk("prerst2_level", 32'(level), 32'd1);
        @(negedge clk) resetn = 1'b0;
        #1;
        check_all_zero("rst_prefix");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(8'h1C);
        chk_head("after_rst2", 1, 8'h1C, 0, 0);
        pop1();

        // Truncated frame: 4 bits, then the bus stalls.
        base = err_pulses;
        send_bits(mk_frame(8'h2B, 0, 0), 4);
`ifdef PS2_RX_TIMEOUT_EN
        n = 15;
        got = -1;
        while (n < 3 * TMO && got < 0) begin
            @(negedge clk);
            n++;
            if (frame_err === 1'b1) got = n;
        end
        chk("timeout_seen", (got >= 0) ? 32'd1 : 32'd0, 32'd1);
        chk("timeout_delay_in_window", (got >= TMO + 2 && got <= TMO + 3) ? 32'd1 : 32'd0, 32'd1);
        repeat (5) @(negedge clk);
        chk("timeout_pulses", 32'(err_pulses - base), 32'd1);
        chk("timeout_err_count", 32'(err_count), 32'd1);
        send_byte(8'h2B);
        chk_head("after_timeout", 1, 8'h2B, 0, 0);
`else
        n = 0;
        got = 0;
        repeat (3 * TMO) @(negedge clk);
        chk("no_timeout_pulses", 32'(err_pulses - base), 32'd0);
        chk("no_timeout_err_count", 32'(err_count), 32'd0);
        chk("no_timeout_level", 32'(level), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
